instruction_fetch: RTL and testbench

Instruction fetch stage for the LEGv8 pipeline. Holds the program counter and drives the instruction memory address. Captures the returned 32-bit instruction, together with its PC, into the IF/ID pipeline register. Handles stall and branch-redirect requests from downstream, and halts when the PC leaves the populated program range so the decoder never sees undefined (X) instruction words.

---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 83 ++++++++
 tb/tb_instruction_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, hazard/branch controls and IF/ID register outputs.
// master = fetch stage, slave = memory plus downstream pipeline.
interface instruction_fetch_if;
    logic [63:0] InstrAddr;
    logic [31:0] Instruction;
    logic        Stall;
    logic        BranchTaken;
    logic [63:0] BranchTarget;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [31:0] FetchCount;

    modport master (
        output InstrAddr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, Halted, FetchCount,
        input  Instruction, Stall, BranchTaken, BranchTarget
    );

    modport slave (
        input  InstrAddr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, Halted, FetchCount,
        output Instruction, Stall, BranchTaken, BranchTarget
    );
endinterface

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC register, IF/ID capture, stall/redirect handling, halt past the program.
// One instruction per cycle; Stall freezes everything, BranchTaken redirects and squashes IF/ID.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] MEM_LIMIT = 64'h60
) (
    input  logic                       CLK,
    input  logic                       Reset,
    instruction_fetch_if.master        bus
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_vld;
    logic [31:0] r_fetch_cnt;

    logic        w_in_range;
    logic        w_fetch;
    logic        w_squash;
    logic        w_halted;
    logic [63:0] w_tgt;

    assign w_in_range = (r_pc < MEM_LIMIT);
    assign w_tgt      = bus.BranchTarget & ~64'h3;

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.BranchTaken)
            w_state_nxt = S_RUN;
        else if (!bus.Stall && r_state == S_RUN && !w_in_range)
            w_state_nxt = S_HALT;
    end

    // Any unstalled cycle that does not fetch leaves IF/ID empty (halt edge, or already halted).
    always_comb begin
        w_fetch  = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            S_RUN:   w_fetch  = !bus.BranchTaken && !bus.Stall && w_in_range;
            S_HALT:  w_halted = 1'b1;
            default: w_halted = 1'b0;
        endcase
        w_squash = bus.BranchTaken || (!bus.Stall && !w_fetch);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc        <= RESET_PC;
            r_if_pc     <= 64'h0;
            r_if_instr  <= 32'h0;
            r_if_vld    <= 1'b0;
            r_fetch_cnt <= 32'h0;
        end else if (bus.BranchTaken) begin
            r_pc     <= w_tgt;
            r_if_vld <= 1'b0;
        end else if (w_fetch) begin
            r_if_pc     <= r_pc;
            r_if_instr  <= bus.Instruction;
            r_if_vld    <= 1'b1;
            r_pc        <= r_pc + 64'd4;
            if (r_fetch_cnt != 32'hFFFF_FFFF)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end else if (w_squash) begin
            r_if_vld <= 1'b0;
        end
    end

    assign bus.InstrAddr   = r_pc;
    assign bus.IF_ID_PC    = r_if_pc;
    assign bus.IF_ID_Instr = r_if_instr;
    assign bus.IF_ID_Valid = r_if_vld;
    assign bus.Halted      = w_halted;
    assign bus.FetchCount  = r_fetch_cnt;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random stall/branch/reset traffic
// checked cycle by cycle against a behavioural model of the fetch rules.
module tb_instruction_fetch;
    localparam logic [63:0] LIMIT = 64'h60;

    logic CLK = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;

    instruction_fetch_if ifc ();

    instruction_fetch #(.RESET_PC(64'h0), .MEM_LIMIT(LIMIT)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (ifc)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [24];

    function automatic logic [31:0] rd_word(input logic [63:0] a);
        if (a < LIMIT) return mem[a[6:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb ifc.Instruction = rd_word(ifc.InstrAddr);

    // Reference state
    logic [63:0] m_pc, m_if_pc;
    logic [31:0] m_if_instr, m_cnt;
    logic        m_vld, m_halted;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic br, input logic [63:0] tgt, input logic stall);
        if (rst) begin
            m_pc = 64'h0; m_if_pc = 64'h0; m_if_instr = 32'h0;
            m_vld = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
        end else if (br) begin
            m_pc = tgt - (tgt % 4);
            m_vld = 1'b0;
            m_halted = 1'b0;
        end else if (stall) begin
            // frozen
        end else if (m_halted || m_pc >= LIMIT) begin
            m_halted = 1'b1;
            m_vld = 1'b0;
        end else begin
            m_if_pc = m_pc;
            m_if_instr = rd_word(m_pc);
            m_vld = 1'b1;
            m_pc = m_pc + 4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all();
        chk("addr",   ifc.InstrAddr,   m_pc);
        chk("if_pc",  ifc.IF_ID_PC,    m_if_pc);
        chk("if_ins", {32'h0, ifc.IF_ID_Instr}, {32'h0, m_if_instr});
        chk("if_vld", {63'h0, ifc.IF_ID_Valid}, {63'h0, m_vld});
        chk("halted", {63'h0, ifc.Halted},      {63'h0, m_halted});
        chk("count",  {32'h0, ifc.FetchCount},  {32'h0, m_cnt});
    endtask

    task automatic step(input logic rst, input logic br, input logic [63:0] tgt, input logic stall);
        Reset = rst;
        ifc.BranchTaken = br;
        ifc.BranchTarget = tgt;
        ifc.Stall = stall;
        @(posedge CLK);
        model_edge(rst, br, tgt, stall);
        #1;
        check_all();
    endtask

    initial begin
        Reset = 1'b1;
        ifc.Stall = 1'b0;
        ifc.BranchTaken = 1'b0;
        ifc.BranchTarget = 64'h0;
        for (int i = 0; i < 24; i++) mem[i] = $urandom;
        mem[0]  = 32'hF840_03E9;
        mem[1]  = 32'hF840_83EA;
        mem[13] = 32'hD282_468A;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_addr",  ifc.InstrAddr, 64'h0);
        chk("rst_vld",   {63'h0, ifc.IF_ID_Valid}, 64'h0);
        chk("rst_count", {32'h0, ifc.FetchCount}, 64'h0);

        // Free run
        step(0, 0, 0, 0);
        chk("e1_pc",  ifc.IF_ID_PC, 64'h0);
        chk("e1_ins", {32'h0, ifc.IF_ID_Instr}, 64'hF84003E9);
        chk("e1_vld", {63'h0, ifc.IF_ID_Valid}, 64'h1);
        step(0, 0, 0, 0);
        chk("e2_pc",  ifc.IF_ID_PC, 64'h4);
        chk("e2_ins", {32'h0, ifc.IF_ID_Instr}, 64'hF84083EA);
        chk("e2_cnt", {32'h0, ifc.FetchCount}, 64'd2);

        // Stall at PC 0x10
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("stall_ifpc", ifc.IF_ID_PC, 64'hC);
            chk("stall_addr", ifc.InstrAddr, 64'h10);
            chk("stall_cnt",  {32'h0, ifc.FetchCount}, 64'd4);
        end
        step(0, 0, 0, 0);
        chk("unstall_ifpc", ifc.IF_ID_PC, 64'h10);

        // Branch with Stall also high
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("pre_br_addr", ifc.InstrAddr, 64'h2C);
        step(0, 1, 64'h1C, 1);
        chk("br_addr", ifc.InstrAddr, 64'h1C);
        chk("br_vld",  {63'h0, ifc.IF_ID_Valid}, 64'h0);
        step(0, 0, 0, 0);
        chk("br_ifpc", ifc.IF_ID_PC, 64'h1C);
        chk("br_ins",  {32'h0, ifc.IF_ID_Instr}, {32'h0, mem[7]});

        // Misaligned target
        step(0, 1, 64'h23, 0);
        chk("mis_addr", ifc.InstrAddr, 64'h20);

        // Run to the limit
        for (int i = 0; i < 40 && ifc.InstrAddr != LIMIT; i++) step(0, 0, 0, 0);
        chk("lim_addr",  ifc.InstrAddr, LIMIT);
        chk("last_ifpc", ifc.IF_ID_PC, 64'h5C);
        step(0, 0, 0, 0);
        chk("halt_h",    {63'h0, ifc.Halted}, 64'h1);
        chk("halt_vld",  {63'h0, ifc.IF_ID_Valid}, 64'h0);
        chk("halt_addr", ifc.InstrAddr, LIMIT);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            chk("halt_hold", {63'h0, ifc.Halted}, 64'h1);
        end

        // Recovery
        step(0, 1, 64'h34, 0);
        chk("rec_h",    {63'h0, ifc.Halted}, 64'h0);
        chk("rec_addr", ifc.InstrAddr, 64'h34);
        step(0, 0, 0, 0);
        chk("rec_ifpc", ifc.IF_ID_PC, 64'h34);
        chk("rec_ins",  {32'h0, ifc.IF_ID_Instr}, 64'hD282468A);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mrst_addr", ifc.InstrAddr, 64'h0);
        chk("mrst_ifpc", ifc.IF_ID_PC, 64'h0);
        chk("mrst_ins",  {32'h0, ifc.IF_ID_Instr}, 64'h0);
        chk("mrst_vld",  {63'h0, ifc.IF_ID_Valid}, 64'h0);
        chk("mrst_h",    {63'h0, ifc.Halted}, 64'h0);
        chk("mrst_cnt",  {32'h0, ifc.FetchCount}, 64'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_br, r_st;
            logic [63:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 2);
            r_br  = ($urandom_range(0, 99) < 8);
            r_st  = ($urandom_range(0, 99) < 25);
            r_tgt = {57'h0, 7'($urandom_range(0, 127))};
            step(r_rst, r_br, r_tgt, r_st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
